// File: rtl/alu_operand_pkg.sv
// alu_operand_pkg: shared operand-select encoding for the ALU operand stage
package alu_operand_pkg;
    typedef enum logic [1:0] {
        SEL_REG  = 2'd0,
        SEL_IMM  = 2'd1,
        SEL_FWD  = 2'd2,
        SEL_ZERO = 2'd3
    } sel_t;
endpackage

// File: rtl/operand_fifo.sv
// operand_fifo: DEPTH-entry FIFO of resolved operand entries
// Ports: clk, rst_n (async active-low), push/pop requests, wdata in,
// rdata out (reads 0 when empty), full/empty flags from the registered count.
module operand_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  T     wdata,
    output T     rdata,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    logic [CW-1:0] count_d, count_q;
    logic          do_push, do_pop;

    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        // Power-of-two depth makes pointer wrap a natural overflow.
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an empty count masks whatever it holds.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: resolves ALU operand sources and buffers them for the ALU
// Ports: clk, rst_n (async active-low); in_valid/in_ready request handshake with
// sel1/sel2 source selects, operand1/operand2, imm/imm_sext, fwd_result/fwd_valid;
// out_valid/out_ready head handshake with alu_op1/alu_op2; stall_cnt (16-bit,
// saturating count of cycles the ALU held off a valid head).
// Macro ALU_OPERAND_FWD_EN enables the forwarding source; without it SEL_FWD
// falls back to the register source and the fwd ports are ignored.
module alu_operand_stage
    import alu_operand_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IMM_W = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       sel1,
    input  logic [1:0]       sel2,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [IMM_W-1:0] imm,
    input  logic             imm_sext,
    input  logic [WIDTH-1:0] fwd_result,
    input  logic             fwd_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [15:0]      stall_cnt
);
`ifdef ALU_OPERAND_FWD_EN
    localparam logic FWD_EN = 1'b1;
`else
    localparam logic FWD_EN = 1'b0;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] op1;
        logic [WIDTH-1:0] op2;
    } entry_t;

    entry_t           wr_entry, rd_entry;
    logic             push, pop, full, empty, fwd_ok;
    logic [WIDTH-1:0] imm_ext;
    logic [15:0]      stall_cnt_d, stall_cnt_q;

    if (IMM_W == WIDTH) begin : g_imm_full
        assign imm_ext = imm;
    end else begin : g_imm_ext
        assign imm_ext = {{(WIDTH - IMM_W){imm_sext & imm[IMM_W-1]}}, imm};
    end

    function automatic logic [WIDTH-1:0] pick(input sel_t s, input logic [WIDTH-1:0] r,
                                              input logic [WIDTH-1:0] i, input logic f,
                                              input logic [WIDTH-1:0] fv);
        return s == SEL_IMM ? i : s == SEL_ZERO ? '0 : (s == SEL_FWD && f) ? fv : r;
    endfunction

    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign alu_op1   = rd_entry.op1;
    assign alu_op2   = rd_entry.op2;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        fwd_ok       = FWD_EN & fwd_valid;
        wr_entry.op1 = pick(sel_t'(sel1), operand1, imm_ext, fwd_ok, fwd_result);
        wr_entry.op2 = pick(sel_t'(sel2), operand2, imm_ext, fwd_ok, fwd_result);
        stall_cnt_d  = (out_valid && !out_ready && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else stall_cnt_q <= stall_cnt_d;
    end

    operand_fifo #(.T(entry_t), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: scoreboard bench for alu_operand_stage (default parameters)
module tb_alu_operand_stage;
    localparam int D = 2;
`ifdef ALU_OPERAND_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk, rst_n, in_valid, in_ready, imm_sext, fwd_valid, out_valid, out_ready;
    logic [1:0]  sel1, sel2;
    logic [7:0]  operand1, operand2, fwd_result, alu_op1, alu_op2;
    logic [3:0]  imm;
    logic [15:0] stall_cnt;

    int          n_cmp, n_err, stall_m;
    logic [15:0] q[$];
    bit          pend_push, pend_pop, pend_stall;
    logic [15:0] pend_val;

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sel1(sel1), .sel2(sel2), .operand1(operand1), .operand2(operand2),
        .imm(imm), .imm_sext(imm_sext), .fwd_result(fwd_result), .fwd_valid(fwd_valid),
        .out_valid(out_valid), .out_ready(out_ready), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_op(input logic [1:0] s, input logic [7:0] r);
        logic [7:0] e;
        e = {imm_sext ? {4{imm[3]}} : 4'h0, imm};
        if (s == 2'd1) return e;
        if (s == 2'd2) return (FWD && fwd_valid) ? fwd_result : r;
        if (s == 2'd3) return 8'h00;
        return r;
    endfunction

    // Compare the DUT against the model mid-cycle, then queue what the next edge should do.
    always @(negedge clk) begin
        check("out_valid", out_valid, q.size() != 0);
        check("in_ready", in_ready, q.size() < D);
        check("stall_cnt", stall_cnt, stall_m);
        if (q.size() != 0) check("head", {alu_op1, alu_op2}, q[0]);
        else check("empty_ops", {alu_op1, alu_op2}, 16'h0000);
        pend_push  = rst_n && in_valid && q.size() < D;
        pend_pop   = q.size() != 0 && out_ready;
        pend_stall = q.size() != 0 && !out_ready;
        pend_val   = {model_op(sel1, operand1), model_op(sel2, operand2)};
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            stall_m = 0;
        end else begin
            if (pend_pop) void'(q.pop_front());
            if (pend_push) q.push_back(pend_val);
            if (pend_stall && stall_m < 16'hFFFF) stall_m++;
        end
    end

    task automatic drive(input logic [1:0] s1, input logic [1:0] s2, input logic [7:0] o1,
                         input logic [7:0] o2, input logic [3:0] im, input logic sx,
                         input logic [7:0] fr, input logic fv);
        sel1 = s1; sel2 = s2; operand1 = o1; operand2 = o2;
        imm = im; imm_sext = sx; fwd_result = fr; fwd_valid = fv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sel1 = 2'd0; sel2 = 2'd0; operand1 = 8'h00; operand2 = 8'h00;
        imm = 4'h0; imm_sext = 1'b0; fwd_result = 8'h00; fwd_valid = 1'b0;
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_ops", {alu_op1, alu_op2}, 16'h0000);
        check("rst_stall", stall_cnt, 16'h0000);
        check("rst_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        drive(2'd0, 2'd1, 8'h3C, 8'h55, 4'hA, 1'b0, 8'h00, 1'b0);
        check("first_valid", out_valid, 1'b1);
        check("first_op1", alu_op1, 8'h3C);
        check("first_op2", alu_op2, 8'h0A);
        drive(2'd0, 2'd1, 8'h00, 8'h00, 4'h9, 1'b1, 8'h00, 1'b0);
        check("imm_sext", alu_op2, 8'hF9);
        drive(2'd0, 2'd3, 8'h00, 8'h44, 4'h9, 1'b1, 8'h00, 1'b0);
        check("sel_zero", alu_op2, 8'h00);
        drive(2'd2, 2'd0, 8'h11, 8'h00, 4'h0, 1'b0, 8'h77, 1'b1);
        check("fwd_valid", alu_op1, FWD ? 8'h77 : 8'h11);
        drive(2'd2, 2'd0, 8'h11, 8'h00, 4'h0, 1'b0, 8'h77, 1'b0);
        check("fwd_invalid", alu_op1, 8'h11);
        @(posedge clk); #1;
        check("drained", out_valid, 1'b0);

        out_ready = 1'b0;
        drive(2'd0, 2'd0, 8'hA1, 8'hA2, 4'h0, 1'b0, 8'h00, 1'b0);
        drive(2'd0, 2'd0, 8'hB1, 8'hB2, 4'h0, 1'b0, 8'h00, 1'b0);
        check("full_ready", in_ready, 1'b0);
        drive(2'd0, 2'd0, 8'hC1, 8'hC2, 4'h0, 1'b0, 8'h00, 1'b0);
        check("stall_two", stall_cnt, 16'd2);
        check("order_a", alu_op1, 8'hA1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("order_b", alu_op1, 8'hB1);
        @(posedge clk); #1;
        check("c_dropped", out_valid, 1'b0);

        out_ready = 1'b0;
        drive(2'd0, 2'd0, 8'hD1, 8'hD2, 4'h0, 1'b0, 8'h00, 1'b0);
        drive(2'd0, 2'd0, 8'hE1, 8'hE2, 4'h0, 1'b0, 8'h00, 1'b0);
        out_ready = 1'b1;
        drive(2'd0, 2'd0, 8'hF1, 8'hF2, 4'h0, 1'b0, 8'h00, 1'b0);
        check("full_pop_valid", out_valid, 1'b1);
        check("full_pop_ready", in_ready, 1'b1);
        check("full_pop_head", alu_op1, 8'hE1);
        @(posedge clk); #1;
        check("full_pop_nostore", out_valid, 1'b0);

        out_ready = 1'b0;
        drive(2'd0, 2'd0, 8'h61, 8'h62, 4'h0, 1'b0, 8'h00, 1'b0);
        drive(2'd0, 2'd0, 8'h71, 8'h72, 4'h0, 1'b0, 8'h00, 1'b0);
        check("pre_rst_stall", stall_cnt != 16'd0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", out_valid, 1'b0);
        check("async_ops", {alu_op1, alu_op2}, 16'h0000);
        check("async_stall", stall_cnt, 16'h0000);
        @(posedge clk); #1 rst_n = 1'b1;
        check("post_rst_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        drive(2'd0, 2'd0, 8'h5A, 8'hA5, 4'h0, 1'b0, 8'h00, 1'b0);
        check("post_rst_push", {alu_op1, alu_op2}, 16'h5AA5);

        for (int i = 0; i < 400; i++) begin
            out_ready  = 1'($urandom_range(0, 1));
            in_valid   = 1'($urandom_range(0, 1));
            sel1       = 2'($urandom);
            sel2       = 2'($urandom);
            operand1   = 8'($urandom);
            operand2   = 8'($urandom);
            imm        = 4'($urandom);
            imm_sext   = 1'($urandom);
            fwd_result = 8'($urandom);
            fwd_valid  = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("final_empty", out_valid, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
